// File: rtl/router_out_arbiter.sv
// router_out_arbiter: round-robin arbiter for one router output with a 1-entry back-pressured output register.
//  clk, rst (async, active-low) | req_data/req_ctrl/req_valid in, req_ready one-hot grant out
//  out_data/out_valid/out_ready: registered output handshake | grant_id: source of out_data | fwd_count: accepted packets
module router_out_arbiter #(
  parameter int WIDTH = 34,
  parameter int NUM_IN = 5,
  parameter logic [1:0] PORT_CODE = 2'b00,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] req_data,
  input  logic [NUM_IN*2-1:0]     req_ctrl,
  input  logic [NUM_IN-1:0]       req_valid,
  output logic [NUM_IN-1:0]       req_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2:0]              grant_id,
  output logic [CNT_W-1:0]        fwd_count
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state, state_nx;
  logic [NUM_IN-1:0] elig;
  logic [2:0] ptr, win, idx;
  logic [3:0] sum;
  logic load_ok, grant;
  for (genvar g = 0; g < NUM_IN; g++) begin : g_elig
    assign elig[g] = req_valid[g] & (req_ctrl[g*2 +: 2] == PORT_CODE);
  end
  // Scan from the farthest candidate back to ptr so the nearest eligible input at/after ptr wins.
  always_comb begin
    win = ptr;
    sum = '0;
    idx = '0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + 4'(k);
      idx = sum >= 4'(NUM_IN) ? 3'(sum - 4'(NUM_IN)) : sum[2:0];
      if (elig[idx]) win = idx;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_nx;
  end
  always_comb state_nx = grant | (out_valid & !out_ready) ? HOLD : IDLE;
  // rst gates the grant so nothing is consumed while reset is asserted.
  always_comb begin
    out_valid = state == HOLD;
    load_ok = (state == IDLE) | (out_ready & out_valid);
    grant = rst & load_ok & |elig;
    req_ready = grant ? {{(NUM_IN-1){1'b0}}, 1'b1} << win : '0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data <= '0;
      grant_id <= '0;
      ptr <= '0;
      fwd_count <= '0;
    end else begin
      if (out_valid & out_ready) fwd_count <= fwd_count + CNT_W'(1);
      if (grant) begin
        out_data <= req_data[win*WIDTH +: WIDTH];
        grant_id <= win;
        ptr <= win == 3'(NUM_IN - 1) ? 3'd0 : win + 3'd1;
      end
    end
  end
endmodule
